// File: rtl/mmio_gpio_pkg.sv
// mmio_gpio_pkg
//   Shared definitions for the memory-mapped GPIO block: bus address width,
//   word-aligned register offsets, and the debounce counter width helper.
//   Used by the RTL decode and by the bench.
package mmio_gpio_pkg;

   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] SW_DATA   = 5'h00;
   localparam logic [ADDR_W-1:0] LED_DATA  = 5'h04;
   localparam logic [ADDR_W-1:0] SW_EDGE   = 5'h08;
   localparam logic [ADDR_W-1:0] LED_BLINK = 5'h0C;
   localparam logic [ADDR_W-1:0] BLINK_DIV = 5'h10;

   // Counter must hold 0..cycles; a zero-cycle debouncer still gets one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce
//   One switch channel: 2-flop synchroniser followed by a consecutive-cycle
//   debouncer. Produces the accepted level and a one-cycle rise pulse that
//   is high during the cycle whose closing edge flips the level 0->1.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset
//   raw    - asynchronous switch input
//   level  - debounced level
//   rise   - combinational pulse: level goes 0->1 on the next edge
module gpio_debounce
   import mmio_gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 230000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

   logic s1;
   logic s2;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         // s1 is what s2 will become, so a pending 0->1 is visible one cycle early.
         assign level = s2;
         assign rise  = s1 & ~s2;
      end else begin : g_count
         // Flip on the edge that would make the count reach DEBOUNCE_CYCLES,
         // so the counter itself never exceeds DEBOUNCE_CYCLES-1.
         localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt;
         logic             lvl;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               cnt <= '0;
               lvl <= 1'b0;
            end else if (s2 == lvl) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               cnt <= '0;
               lvl <= s2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         assign level = lvl;
         assign rise  = s2 & ~lvl & (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/mmio_gpio.sv
// mmio_gpio
//   Memory-mapped GPIO: NUM_SW debounced switches with sticky rising-edge
//   flags, NUM_LED LEDs with data register and per-bit blink.
//   Registers: 0x00 SW_DATA (R), 0x04 LED_DATA (R/W), 0x08 SW_EDGE (R/W1C),
//              0x0C LED_BLINK (R/W), 0x10 BLINK_DIV (R/W, half-period).
// Ports:
//   clock, reset          - system clock, async active-low reset
//   ioRead, ioWrite       - bus strobes
//   addr                  - byte address, addr[1:0] ignored
//   write_data, read_data - bus data; reads are combinational
//   switches              - raw switch inputs
//   leds                  - LED drive
module mmio_gpio
   import mmio_gpio_pkg::*;
#(
   parameter int NUM_SW          = 24,
   parameter int NUM_LED         = 24,
   parameter int DEBOUNCE_CYCLES = 230000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ioRead,
   input  logic               ioWrite,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   input  logic [NUM_SW-1:0]  switches,
   output logic [NUM_LED-1:0] leds
);

   logic [NUM_SW-1:0]  sw_level;
   logic [NUM_SW-1:0]  sw_rise;
   logic [NUM_SW-1:0]  sw_edge;
   logic [NUM_LED-1:0] led_data;
   logic [NUM_LED-1:0] led_blink;
   logic [31:0]        blink_div;
   logic [31:0]        blink_cnt;
   logic               phase;

   logic [ADDR_W-1:0]  word_addr;
   logic               unused_addr;
   logic               wr_led;
   logic               wr_edge;
   logic               wr_blink;
   logic               wr_div;

   generate
      for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
         gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clock(clock),
            .reset(reset),
            .raw  (switches[i]),
            .level(sw_level[i]),
            .rise (sw_rise[i])
         );
      end
   endgenerate

   assign word_addr   = {addr[ADDR_W-1:2], 2'b00};
   assign unused_addr = &{1'b0, addr[1:0]};

   assign wr_led   = ioWrite && (word_addr == LED_DATA);
   assign wr_edge  = ioWrite && (word_addr == SW_EDGE);
   assign wr_blink = ioWrite && (word_addr == LED_BLINK);
   assign wr_div   = ioWrite && (word_addr == BLINK_DIV);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         led_data  <= '0;
         led_blink <= '0;
         blink_div <= '0;
         sw_edge   <= '0;
      end else begin
         if (wr_led)   led_data  <= write_data[NUM_LED-1:0];
         if (wr_blink) led_blink <= write_data[NUM_LED-1:0];
         if (wr_div)   blink_div <= write_data;
         // OR-ing the rise pulses in last makes a coincident set beat the clear.
         sw_edge <= (sw_edge & ~(wr_edge ? write_data[NUM_SW-1:0] : '0)) | sw_rise;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (wr_div || (blink_div == 32'd0)) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == blink_div - 32'd1) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 32'd1;
      end
   end

   assign leds = led_data & ~(led_blink & {NUM_LED{phase}});

   always_comb begin
      read_data = '0;
      if (ioRead) begin
         case (word_addr)
            SW_DATA:   read_data = 32'(sw_level);
            LED_DATA:  read_data = 32'(led_data);
            SW_EDGE:   read_data = 32'(sw_edge);
            LED_BLINK: read_data = 32'(led_blink);
            BLINK_DIV: read_data = blink_div;
            default:   read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio
//   Self-checking bench for mmio_gpio (8 switches, 8 LEDs, 4-cycle debounce).
//   Directed scenarios followed by randomized bus/switch traffic, checked
//   against a behavioural model: debounce as a sliding window over sampled
//   switch history, blink phase as (cycles since divider load / div) mod 2.
module tb_mmio_gpio;
   import mmio_gpio_pkg::*;

   localparam int NSW = 8;
   localparam int NLED = 8;
   localparam int DB = 4;

   logic        clock;
   logic        reset;
   logic        ioRead;
   logic        ioWrite;
   logic [4:0]  addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic [7:0]  switches;
   logic [7:0]  leds;

   int n_checks = 0;
   int n_errors = 0;

   mmio_gpio #(
      .NUM_SW(NSW),
      .NUM_LED(NLED),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ioRead    (ioRead),
      .ioWrite   (ioWrite),
      .addr      (addr),
      .write_data(write_data),
      .read_data (read_data),
      .switches  (switches),
      .leds      (leds)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // reference model state
   logic [7:0]  m_level;
   logic [7:0]  m_led;
   logic [7:0]  m_blink;
   logic [7:0]  m_edge;
   int unsigned m_div;
   int unsigned m_t;
   logic [7:0]  m_hist[$];   // m_hist[k] = switches sampled k+1 edges ago

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_level = '0;
      m_led   = '0;
      m_blink = '0;
      m_edge  = '0;
      m_div   = 0;
      m_t     = 0;
      m_hist.delete();
      for (int k = 0; k < DB + 2; k++) m_hist.push_back(8'h00);
   endtask

   function automatic logic m_phase();
      if (m_div == 0) return 1'b0;
      return ((m_t / m_div) % 2) == 1;
   endfunction

   function automatic logic [7:0] exp_leds();
      return m_led & ~(m_blink & {8{m_phase()}});
   endfunction

   function automatic logic [31:0] exp_rd(input logic rd, input logic [4:0] a);
      if (!rd) return 32'h0;
      case ({a[4:2], 2'b00})
         SW_DATA:   return {24'h0, m_level};
         LED_DATA:  return {24'h0, m_led};
         SW_EDGE:   return {24'h0, m_edge};
         LED_BLINK: return {24'h0, m_blink};
         BLINK_DIV: return m_div;
         default:   return 32'h0;
      endcase
   endfunction

   // Advance the model over one clock edge using the inputs present at it.
   task automatic model_edge();
      logic [7:0] new_level;
      logic [7:0] rise;
      logic [7:0] clr;
      logic [4:0] word;
      new_level = m_level;
      // A level flips once the synchronised input (two samples late) has
      // disagreed with it for DB consecutive edges.
      for (int i = 0; i < 8; i++) begin
         bit all_diff;
         all_diff = 1'b1;
         for (int j = 1; j <= DB; j++)
            if (m_hist[j][i] == m_level[i]) all_diff = 1'b0;
         if (all_diff) new_level[i] = ~m_level[i];
      end
      m_hist.push_front(switches);
      void'(m_hist.pop_back());
      rise = new_level & ~m_level;
      word = {addr[4:2], 2'b00};
      clr  = (ioWrite && word == SW_EDGE) ? write_data[7:0] : 8'h00;
      m_edge = (m_edge & ~clr) | rise;
      if (ioWrite && word == LED_DATA)  m_led   = write_data[7:0];
      if (ioWrite && word == LED_BLINK) m_blink = write_data[7:0];
      if (ioWrite && word == BLINK_DIV) begin
         m_div = write_data;
         m_t   = 0;
      end else if (m_div == 0) begin
         m_t = 0;
      end else begin
         m_t++;
      end
      m_level = new_level;
   endtask

   // Drive one cycle of inputs, check combinational outputs before the edge,
   // then take the edge and return 1 time unit after it.
   task automatic step(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [31:0] wd, input logic [7:0] sw);
      ioRead     = rd;
      ioWrite    = wr;
      addr       = a;
      write_data = wd;
      switches   = sw;
      #1;
      check_val("leds", {24'h0, leds}, {24'h0, exp_leds()});
      check_val("read_data", read_data, exp_rd(rd, a));
      @(posedge clock);
      model_edge();
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle with traffic still present.
   task automatic reset_pulse();
      reset      = 1'b0;
      ioRead     = 1'b1;
      ioWrite    = 1'b1;
      addr       = LED_DATA;
      write_data = 32'hFFFF_FFFF;
      switches   = 8'hFF;
      model_reset();
      #1;
      check_val("rst_leds", {24'h0, leds}, 32'h0);
      check_val("rst_rd", read_data, 32'h0);
      @(posedge clock);
      #1;
      check_val("rst_leds_hold", {24'h0, leds}, 32'h0);
      check_val("rst_rd_hold", read_data, 32'h0);
      ioWrite  = 1'b0;
      switches = 8'h00;
      #2 reset = 1'b1;
      #1;
   endtask

   initial begin
      logic [7:0] cur_sw;
      reset      = 1'b0;
      ioRead     = 1'b0;
      ioWrite    = 1'b0;
      addr       = '0;
      write_data = '0;
      switches   = '0;
      model_reset();

      // 1. reset
      @(posedge clock);
      #1;
      reset_pulse();
      step(1, 0, SW_DATA, 0, 8'h00);
      check_val("first_read", read_data, 32'h0);

      // 2. debounce latency and glitch rejection
      for (int k = 0; k <= 5; k++) begin
         step(1, 0, SW_DATA, 0, 8'h01);
         check_val("deb_latency", read_data, (k < 5) ? 32'h0 : 32'h1);
      end
      for (int k = 0; k < 3; k++) step(1, 0, SW_DATA, 0, 8'h03);
      for (int k = 0; k < 8; k++) step(1, 0, SW_DATA, 0, 8'h01);
      check_val("glitch", read_data, 32'h1);

      // 3. edge capture and W1C, set wins over clear
      step(1, 0, SW_EDGE, 0, 8'h01);
      check_val("edge_set", read_data, 32'h1);
      step(0, 1, SW_EDGE, 32'h1, 8'h01);
      step(1, 0, SW_EDGE, 0, 8'h01);
      check_val("edge_w1c", read_data, 32'h0);
      for (int k = 0; k < 5; k++) step(1, 0, SW_EDGE, 0, 8'h03);
      step(0, 1, SW_EDGE, 32'h2, 8'h03);
      step(1, 0, SW_EDGE, 0, 8'h03);
      check_val("edge_set_wins", read_data, 32'h2);

      // 4. LED read/write
      step(0, 1, LED_DATA, 32'hA5, 8'h03);
      check_val("led_a5", {24'h0, leds}, 32'hA5);
      step(1, 0, LED_DATA, 0, 8'h03);
      check_val("led_rd_a5", read_data, 32'hA5);
      step(0, 1, LED_DATA, 32'hFFFF_FFFF, 8'h03);
      step(1, 0, LED_DATA, 0, 8'h03);
      check_val("led_trunc", read_data, 32'hFF);

      // 5. blink
      step(0, 1, LED_BLINK, 32'h0F, 8'h03);
      step(0, 1, BLINK_DIV, 32'h3, 8'h03);
      for (int k = 0; k < 12; k++) begin
         check_val("blink_seq", {24'h0, leds}, ((k / 3) % 2 == 1) ? 32'hF0 : 32'hFF);
         step(0, 0, LED_DATA, 0, 8'h03);
      end
      step(0, 1, BLINK_DIV, 32'h0, 8'h03);
      for (int k = 0; k < 6; k++) begin
         check_val("blink_off", {24'h0, leds}, 32'hFF);
         step(0, 0, LED_DATA, 0, 8'h03);
      end

      // 6. bus edge cases
      step(0, 1, 5'h14, 32'hDEAD_BEEF, 8'h03);
      step(1, 0, 5'h14, 0, 8'h03);
      check_val("unmapped_rd", read_data, 32'h0);
      step(0, 0, LED_DATA, 0, 8'h03);
      check_val("no_ioread", read_data, 32'h0);
      step(0, 1, SW_DATA, 32'hFF, 8'h03);
      step(1, 0, SW_DATA, 0, 8'h03);
      check_val("sw_data_ro", read_data, 32'h3);
      step(1, 0, 5'h05, 0, 8'h03);
      check_val("low_addr_ignored", read_data, 32'hFF);

      // randomized traffic
      cur_sw = 8'h03;
      for (int i = 0; i < 1500; i++) begin
         logic        rd;
         logic        wr;
         logic [4:0]  a;
         logic [31:0] wd;
         if (i == 700) reset_pulse();
         if ($urandom_range(0, 7) == 0) cur_sw = cur_sw ^ 8'($urandom);
         rd = 1'($urandom);
         wr = ($urandom_range(0, 3) == 0);
         a  = {3'($urandom_range(0, 7)), 2'($urandom)};
         wd = $urandom;
         if ({a[4:2], 2'b00} == BLINK_DIV) wd = $urandom_range(0, 5);
         step(rd, wr, a, wd, cur_sw);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
